// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipe: mode encoding,
// occupancy states and FIFO depth.
package imm_ext_pkg;

    // Extension mode as carried on in_mode
    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b01,
        EXT_ONES = 2'b10,
        EXT_SHL1 = 2'b11
    } ext_mode_e;

    // Occupancy of the output FIFO
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } occ_e;

    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for imm_ext_pipe: input offer side and output result side.
// slave = the pipe itself, master = the producer/consumer environment.
interface imm_ext_pipe_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_neg;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_neg
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_neg
    );
endinterface

// File: rtl/imm_ext_pipe_ext_core.sv
// Combinational field extender. Optional mode-11 shifter is enabled by
// defining IMM_EXT_SHIFT_EN; otherwise mode 11 behaves as sign extension.
module ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  data,
    input  ext_mode_e        mode,
    output logic [OUT_W-1:0] result
);

    logic [OUT_W-1:0] sgn;

    assign sgn = {{(OUT_W-IN_W){data[IN_W-1]}}, data};

    // Select fill pattern by mode
    always_comb begin
        result = sgn;
        case (mode)
            EXT_ZERO: result = {{(OUT_W-IN_W){1'b0}}, data};
            EXT_ONES: result = {{(OUT_W-IN_W){1'b1}}, data};
`ifdef IMM_EXT_SHIFT_EN
            EXT_SHL1: result = sgn << 1;
`endif
            default:  result = sgn;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension pipe: extends the offered field at accept time and
// buffers results in a 2-entry FIFO. in_ready/out_valid are registered so
// there is no combinational path from out_ready to in_ready.
// Optional feature macro: IMM_EXT_SHIFT_EN (mode 11 = sign then shift-left-1).
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    imm_ext_pipe_if.slave  bus
);

    occ_e             state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rdy_q;
    logic             vld_q;
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [OUT_W-1:0] ext_res;
    logic             push;
    logic             pop;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .data   (bus.in_data),
        .mode   (ext_mode_e'(bus.in_mode)),
        .result (ext_res)
    );

    assign push = bus.in_valid && rdy_q;
    assign pop  = vld_q && bus.out_ready;

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_neg   = mem[rd_ptr][OUT_W-1];

    // Occupancy FSM, pointers, storage and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // flush beats any same-cycle push or pop
            state  <= ST_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ext_res;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                ST_EMPTY: if (push) begin
                    state <= ST_ONE;
                    vld_q <= 1'b1;
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state <= ST_FULL;
                        rdy_q <= 1'b0;
                    end else if (pop && !push) begin
                        state <= ST_EMPTY;
                        vld_q <= 1'b0;
                    end
                end
                ST_FULL: if (pop) begin
                    state <= ST_ONE;
                    rdy_q <= 1'b1;
                end
                default: begin
                    state <= ST_EMPTY;
                    rdy_q <= 1'b1;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe (IN_W=2, OUT_W=8).
module tb_imm_ext_pipe;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   tests = 0;
    int   fails = 0;

    imm_ext_pipe_if #(.IN_W(2), .OUT_W(8)) bus ();

    imm_ext_pipe #(.IN_W(2), .OUT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // advance one edge; inputs change and outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [1:0] d, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
    endtask

`ifdef IMM_EXT_SHIFT_EN
    localparam logic [7:0] SHL_10 = 8'hFC;
    localparam logic [7:0] SHL_01 = 8'h02;
`else
    localparam logic [7:0] SHL_10 = 8'hFE;
    localparam logic [7:0] SHL_01 = 8'h01;
`endif

    logic [1:0] vd [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] vm [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] ve [8];
    logic [7:0] sgn_tab [4] = '{8'h00, 8'h01, 8'hFE, 8'hFF};

    initial begin
        ve = '{8'hFE, 8'h02, 8'hFE, SHL_10, 8'h01, 8'h01, 8'hFD, SHL_01};
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = '0; bus.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_data",  32'(bus.out_data),  32'h00);
        chk("rst_out_neg",   32'(bus.out_neg),   32'd0);

        // mode table, one at a time, each visible one cycle after accept
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(vd[i], vm[i]);
            chk($sformatf("mode%0d_pre_valid", i), 32'(bus.out_valid), 32'd0);
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("mode%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("mode%0d_data", i),  32'(bus.out_data),  32'(ve[i]));
            chk($sformatf("mode%0d_neg", i),   32'(bus.out_neg),   32'(ve[i][7]));
            step();
        end
        chk("mode_drained", 32'(bus.out_valid), 32'd0);

        // backpressure: A=01/sign->01, B=10/zero->02, C=01/ones->FD
        bus.out_ready = 1'b0;
        offer(2'b01, 2'b00); step();
        chk("bp_ready_after1", 32'(bus.in_ready), 32'd1);
        offer(2'b10, 2'b01); step();
        chk("bp_ready_after2", 32'(bus.in_ready), 32'd0);
        chk("bp_head_a",       32'(bus.out_data), 32'h01);
        offer(2'b01, 2'b10); step();
        chk("bp_still_full",   32'(bus.in_ready), 32'd0);
        chk("bp_hold_data",    32'(bus.out_data), 32'h01);
        chk("bp_hold_valid",   32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1; step();         // pops A, C still held off
        chk("bp_head_b",       32'(bus.out_data), 32'h02);
        chk("bp_ready_again",  32'(bus.in_ready), 32'd1);
        step();                               // pushes C, pops B
        bus.in_valid = 1'b0;
        chk("bp_head_c",       32'(bus.out_data), 32'hFD);
        chk("bp_neg_c",        32'(bus.out_neg),  32'd1);
        step();
        chk("bp_empty",        32'(bus.out_valid), 32'd0);

        // steady push+pop in ONE: stream of sign-extended 0,1,2,3,...
        offer(2'd0, 2'b00); step();
        chk("pp_first", 32'(bus.out_data), 32'(sgn_tab[0]));
        for (int i = 1; i <= 10; i++) begin
            offer(2'(i % 4), 2'b00);
            step();
            chk($sformatf("pp%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("pp%0d_ready", i), 32'(bus.in_ready),  32'd1);
            chk($sformatf("pp%0d_data", i),  32'(bus.out_data),  32'(sgn_tab[i % 4]));
        end
        bus.in_valid = 1'b0; step();
        chk("pp_drained", 32'(bus.out_valid), 32'd0);

        // flush in FULL with a same-cycle offer
        bus.out_ready = 1'b0;
        offer(2'b10, 2'b00); step();
        offer(2'b01, 2'b00); step();
        chk("fl_full", 32'(bus.in_ready), 32'd0);
        offer(2'b01, 2'b10);
        flush = 1'b1; step();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_ready", 32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        step(); step();
        chk("fl_nothing_out", 32'(bus.out_valid), 32'd0);

        // reset mid-stream while FULL
        bus.out_ready = 1'b0;
        offer(2'b10, 2'b10); step();
        offer(2'b01, 2'b01); step();
        chk("rs_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; bus.in_valid = 1'b0;
        chk("rs_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_ready", 32'(bus.in_ready),  32'd1);
        chk("rs_data",  32'(bus.out_data),  32'h00);
        chk("rs_neg",   32'(bus.out_neg),   32'd0);
        offer(2'b10, 2'b11); step();
        bus.in_valid = 1'b0;
        chk("rs_post_valid", 32'(bus.out_valid), 32'd1);
        chk("rs_post_data",  32'(bus.out_data),  32'(SHL_10));
        step();
        chk("rs_post_empty", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 2, meaning the input field width in bits, legal range 1..OUT_W-1.
REQ-002 SHALL have parameter OUT_W, default 8, meaning the extended output width in bits, legal range 2..32.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data/in_mode are offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts the offer this cycle.
REQ-008 SHALL have port in_data, input, IN_W, the field to extend.
REQ-009 SHALL have port in_mode, input, 2: 00 sign, 01 zero, 10 ones-fill, 11 sign then shift-left-1.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data/out_neg hold a valid result.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-012 SHALL have port out_data, output, OUT_W, the extended result.
REQ-013 SHALL have port out_neg, output, 1, the MSB of out_data for the head entry.

Function
REQ-014 SHALL compute mode 00 as {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}.
REQ-015 SHALL compute mode 01 as the zero-filled value and mode 10 as the ones-filled value.
REQ-016 SHALL compute mode 11 as the mode-00 result shifted left one bit, LSB 0, with the MSB discarded.
REQ-017 SHALL compute the extension at accept time and store the result in a 2-entry FIFO.
REQ-018 SHALL accept a transfer when in_valid&&in_ready, and SHALL complete an output when out_valid&&out_ready.
REQ-019 SHALL have a latency of exactly 1 cycle: data accepted in cycle N is presented with out_valid high in cycle N+1 at the earliest.
REQ-020 SHALL implement the occupancy FSM EMPTY->ONE on push, ONE->FULL on push without pop, ONE->EMPTY on pop without push, FULL->ONE on pop, and stay in the current state on simultaneous push+pop in ONE.
REQ-021 SHALL drive in_ready = (state != FULL), registered with no combinational path from out_ready.
REQ-022 SHALL drive out_valid = (state != EMPTY), with out_data taken from the oldest entry.
REQ-023 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL give flush priority over push and pop: next state EMPTY and the same-cycle offer dropped, although in_ready may be high.
REQ-025 SHALL wrap the read and write pointers modulo 2.

Reset
REQ-026 SHALL, when rst is high at a clock edge, set state EMPTY, both pointers 0, out_valid 0, in_ready 1, out_data 0 and out_neg 0, with rst dominating flush and all handshakes.
REQ-027 SHALL discard all entries on reset asserted mid-operation, with no output completion in that cycle.

Configuration
REQ-028 SHALL, with macro IMM_EXT_SHIFT_EN defined, implement mode 11 per REQ-016.
REQ-029 SHALL, without IMM_EXT_SHIFT_EN, treat mode 11 identically to mode 00 and include no shifter logic.

Structure
REQ-030 SHALL place the mode encoding typedef (EXT_SIGN, EXT_ZERO, EXT_ONES, EXT_SHL1) and the FIFO depth constant 2 in package imm_ext_pkg.
REQ-031 SHALL implement the extension in a combinational sub-module ext_core (IN_W/OUT_W parameters, data+mode in, result out), with the FIFO and FSM in imm_ext_pipe.

Verification (IN_W=2, OUT_W=8, IMM_EXT_SHIFT_EN defined unless noted)
REQ-032 SHALL cover: modes 00/01/10/11 with in_data=2'b10 -> out_data 8'hFE/8'h02/8'hFE/8'hFC, and in_data=2'b01 -> 8'h01/8'h01/8'hFD/8'h02, out_neg matching the MSB, each one cycle after accept.
REQ-033 SHALL cover: out_ready=0 while pushing 3 values -> in_ready low after the 2nd push, 3rd held by the source; then out_ready=1 -> outputs in FIFO order with no loss or duplication.
REQ-034 SHALL cover: FSM in ONE, simultaneous push+pop for 10 cycles -> state stays ONE and the stream is delivered in order.
REQ-035 SHALL cover: flush and in_valid together in FULL -> next cycle out_valid=0 and in_ready=1, with the offered value never output.
REQ-036 SHALL cover: rst asserted mid-stream in FULL -> next cycle all outputs at reset values, then the first post-reset push outputs correctly.
REQ-037 SHALL cover: build without IMM_EXT_SHIFT_EN, mode 11 with in_data=2'b10 -> out_data 8'hFE.
